// File: rtl/dm_responder_pkg.sv
// rtl/dm_responder_pkg.sv - shared width encodings and FSM states for the data-memory responder
package dm_responder_pkg;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - little-endian lane steering for stores and load extract/extend
module dm_lane_align
  import dm_responder_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] load,
  output logic        err
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rword >> {addr_lo, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_lo[1] ? rword[31:16] : rword[15:0];

    err   = 1'b0;
    be    = 4'h0;
    wword = wdata;
    load  = rword;
    case (width)
      W_WORD: begin
        err = (addr_lo != 2'b00);
        be  = 4'hF;
      end
      W_HALF: begin
        err   = addr_lo[0];
        be    = addr_lo[1] ? 4'hC : 4'h3;
        wword = {2{wdata[15:0]}};
        load  = {{16{sext & half_v[15]}}, half_v};
      end
      W_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        load  = {{24{sext & byte_v[7]}}, byte_v};
      end
      default: err = 1'b1;
    endcase
    // A faulted request must never touch the array.
    if (err) be = 4'h0;
  end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - wait-stated data-memory responder with req/ack handshake
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  width,
  input  logic        sext,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];

  logic              c_we, c_sext;
  logic [ADDR_BITS+1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [1:0]        c_width;

  logic              a_we, a_sext, a_err, access;
  logic [ADDR_BITS+1:0] a_addr;
  logic [31:0]       a_wdata, a_wword, a_load, a_rword;
  logic [1:0]        a_width;
  logic [3:0]        a_be;
  logic [ADDR_BITS-1:0] idx;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_BITS+2];

  // With zero wait states the access happens on the accept edge, so the live inputs are used.
  always_comb begin
    if (state == IDLE) begin
      a_we = we; a_sext = sext; a_addr = addr[ADDR_BITS+1:0];
      a_wdata = wdata; a_width = width;
    end else begin
      a_we = c_we; a_sext = c_sext; a_addr = c_addr;
      a_wdata = c_wdata; a_width = c_width;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY:    if (cnt == 4'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign access  = (state_nx == DONE) && (state != DONE);
  assign idx     = a_addr[ADDR_BITS+1:2];
  assign a_rword = mem[idx];
  assign busy    = (state != IDLE);
  assign ack     = (state == DONE);

  dm_lane_align u_align (
    .width   (a_width),
    .addr_lo (a_addr[1:0]),
    .sext    (a_sext),
    .wdata   (a_wdata),
    .rword   (a_rword),
    .be      (a_be),
    .wword   (a_wword),
    .load    (a_load),
    .err     (a_err)
  );

  // Array is never cleared; the reset term only blocks a commit coinciding with reset.
  always_ff @(posedge clk) begin
    if (access && a_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem[idx][8*i +: 8] <= a_wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      err     <= 1'b0;
      rdata   <= 32'd0;
      c_we    <= 1'b0;
      c_sext  <= 1'b0;
      c_addr  <= '0;
      c_wdata <= 32'd0;
      c_width <= W_WORD;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        cnt     <= 4'(WAIT_CYCLES);
        c_we    <= we;
        c_sext  <= sext;
        c_addr  <= addr[ADDR_BITS+1:0];
        c_wdata <= wdata;
        c_width <= width;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      err <= access && a_err;
      if (access && !a_err && !a_we) rdata <= a_load;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench for dm_responder
module tb_dm_responder;

  logic clk = 1'b0;
  logic reset;
  logic req, we, sext;
  logic [31:0] addr, wdata;
  logic [1:0] width;
  logic busy, ack, err;
  logic [31:0] rdata;

  logic req0, we0, sext0;
  logic [31:0] addr0, wdata0;
  logic [1:0] width0;
  logic busy0, ack0, err0;
  logic [31:0] rdata0;

  int n_cmp = 0;
  int n_bad = 0;
  logic        r_err;
  logic [31:0] r_data;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .width(width), .sext(sext), .busy(busy), .ack(ack), .err(err), .rdata(rdata)
  );

  dm_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .width(width0), .sext(sext0), .busy(busy0), .ack(ack0), .err(err0), .rdata(rdata0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on the WAIT_CYCLES=2 instance, starting from IDLE at #1 after an edge.
  task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] wd, input logic s,
                        output logic e, output logic [31:0] rd);
    int n;
    req = 1'b1; we = w; addr = a; wdata = d; width = wd; sext = s;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_5555;
    n = 1;
    while (!ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    e  = err;
    rd = rdata;
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, {31'd0, ack}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; width = 2'b00; sext = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; width0 = 2'b00; sext0 = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_req("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, r_err, r_data);
    check("st_word_err", {31'd0, r_err}, 32'd0);
    do_req("ld_word", 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, r_err, r_data);
    check("ld_word_err", {31'd0, r_err}, 32'd0);
    check("ld_word_data", r_data, 32'hDEADBEEF);

    do_req("st_byte", 1'b1, 32'h11, 32'h0000007F, 2'b10, 1'b0, r_err, r_data);
    check("st_byte_err", {31'd0, r_err}, 32'd0);
    do_req("ld_byte_s", 1'b0, 32'h11, 32'h0, 2'b10, 1'b1, r_err, r_data);
    check("ld_byte_s_data", r_data, 32'h0000007F);
    do_req("ld_word2", 1'b0, 32'h10, 32'h0, 2'b00, 1'b1, r_err, r_data);
    check("ld_word2_data", r_data, 32'hDEAD7FEF);
    do_req("ld_half_s", 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, r_err, r_data);
    check("ld_half_s_data", r_data, 32'hFFFFDEAD);
    do_req("ld_half_u", 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, r_err, r_data);
    check("ld_half_u_data", r_data, 32'h0000DEAD);
    do_req("ld_byte3_s", 1'b0, 32'h13, 32'h0, 2'b10, 1'b1, r_err, r_data);
    check("ld_byte3_s_data", r_data, 32'hFFFFFFDE);
    do_req("ld_byte0_u", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, r_err, r_data);
    check("ld_byte0_u_data", r_data, 32'h000000EF);
    // Upper address bits ignored: 0x1010 aliases word index 4 (0x10).
    do_req("ld_wrap", 1'b0, 32'h0000_1010, 32'h0, 2'b00, 1'b0, r_err, r_data);
    check("ld_wrap_data", r_data, 32'hDEAD7FEF);

    do_req("st_mis", 1'b1, 32'h13, 32'h12345678, 2'b00, 1'b0, r_err, r_data);
    check("st_mis_err", {31'd0, r_err}, 32'd1);
    do_req("st_mis_half", 1'b1, 32'h11, 32'h0000AAAA, 2'b01, 1'b0, r_err, r_data);
    check("st_mis_half_err", {31'd0, r_err}, 32'd1);
    do_req("ld_after_mis", 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, r_err, r_data);
    check("ld_after_mis_err", {31'd0, r_err}, 32'd0);
    check("ld_after_mis_data", r_data, 32'hDEAD7FEF);

    do_req("ld_rsvd", 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, r_err, r_data);
    check("ld_rsvd_err", {31'd0, r_err}, 32'd1);
    check("ld_rsvd_data", r_data, 32'hDEAD7FEF);
    check("err_clears", {31'd0, err}, 32'd0);

    // Zero-wait instance: req held high across two back-to-back requests.
    check("z_idle_busy", {31'd0, busy0}, 32'd0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hCAFE1234; width0 = 2'b00;
    @(posedge clk); #1;
    check("z_c1_ack", {31'd0, ack0}, 32'd1);
    check("z_c1_busy", {31'd0, busy0}, 32'd1);
    we0 = 1'b0;
    @(posedge clk); #1;
    check("z_c2_ack", {31'd0, ack0}, 32'd0);
    check("z_c2_busy", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1;
    check("z_c3_ack", {31'd0, ack0}, 32'd1);
    check("z_c3_busy", {31'd0, busy0}, 32'd1);
    check("z_c3_rdata", rdata0, 32'hCAFE1234);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("z_c4_ack", {31'd0, ack0}, 32'd0);
    check("z_c4_busy", {31'd0, busy0}, 32'd0);

    // Reset during BUSY of a store must abort it.
    do_req("st_zero", 1'b1, 32'h20, 32'h0, 2'b00, 1'b0, r_err, r_data);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAAAAAA; width = 2'b00;
    @(posedge clk); #1;
    req = 1'b0;
    check("rb_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rb_busy", {31'd0, busy}, 32'd0);
    check("rb_ack", {31'd0, ack}, 32'd0);
    check("rb_err", {31'd0, err}, 32'd0);
    check("rb_rdata", rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rb_no_ack", {31'd0, ack}, 32'd0);
    end
    do_req("ld_after_rst", 1'b0, 32'h20, 32'h0, 2'b00, 1'b0, r_err, r_data);
    check("ld_after_rst_data", r_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
